// File: rtl/sd_drive_arbiter.sv
// Round-robin arbiter sharing one user_io SD sector port between floppy drives A and B.
// One drive is granted per sector; strobes are routed to it and the byte count is checked.
module sd_drive_arbiter #(
  parameter int unsigned TIMEOUT_W  = 20,
  parameter int unsigned SECTOR_LEN = 512
) (
  input  logic        clk_sys,
  input  logic        res_n,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  input  logic [7:0]  drv_din0,
  input  logic [7:0]  drv_din1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic [1:0]  drv_dout_strobe,
  output logic [1:0]  drv_din_strobe,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  output logic [7:0]  sd_din,
  input  logic        sd_ack,
  input  logic        sd_dout_strobe,
  input  logic        sd_din_strobe
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StFin} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic [31:0]            lba_q, lba_d;
  logic [1:0]             rd_q, rd_d;
  logic [1:0]             wr_q, wr_d;
  logic                   last_q, last_d;
  logic                   is_rd_q, is_rd_d;
  logic [9:0]             cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;

  logic [1:0] pending;
  logic       sel;
  logic       xfer;
  logic       cnt_strobe;

  assign pending = req_rd | req_wr;
  // Single requester wins outright; on a tie the drive not served last wins.
  assign sel     = (pending == 2'b11) ? ~last_q : pending[1];
  assign xfer    = (state_q == StXfer);
  assign cnt_strobe = is_rd_q ? sd_dout_strobe : sd_din_strobe;

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      lba_q   <= 32'd0;
      rd_q    <= 2'b00;
      wr_q    <= 2'b00;
      last_q  <= 1'b1;
      is_rd_q <= 1'b0;
      cnt_q   <= 10'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      is_rd_q <= is_rd_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    last_d  = last_q;
    is_rd_d = is_rd_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    done    = 2'b00;
    err     = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (|pending) begin
          grant_d = sel ? 2'b10 : 2'b01;
          lba_d   = sel ? req_lba1 : req_lba0;
          is_rd_d = req_rd[sel];
          rd_d    = req_rd[sel] ? grant_d : 2'b00;
          wr_d    = req_rd[sel] ? 2'b00 : grant_d;
          last_d  = sel;
          cnt_d   = 10'd0;
          tmo_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        tmo_d = tmo_q + 1'b1;
        if (sd_ack) begin
          rd_d    = 2'b00;
          wr_d    = 2'b00;
          state_d = StXfer;
        end else if (&tmo_q) begin
          rd_d    = 2'b00;
          wr_d    = 2'b00;
          err     = grant_q;
          grant_d = 2'b00;
          state_d = StIdle;
        end
      end
      StXfer: begin
        if (cnt_strobe && (cnt_q != 10'h3ff)) begin
          cnt_d = cnt_q + 10'd1;
        end
        if (!sd_ack) begin
          state_d = StFin;
        end
      end
      StFin: begin
        if (cnt_q == 10'(SECTOR_LEN)) begin
          done = grant_q;
        end else begin
          err = grant_q;
        end
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant           = grant_q;
  assign busy            = (state_q != StIdle);
  assign sd_lba          = lba_q;
  assign sd_rd           = rd_q;
  assign sd_wr           = wr_q;
  assign drv_dout_strobe = (xfer && sd_dout_strobe) ? grant_q : 2'b00;
  assign drv_din_strobe  = (xfer && sd_din_strobe) ? grant_q : 2'b00;
  assign sd_din          = grant_q[1] ? drv_din1 : (grant_q[0] ? drv_din0 : 8'd0);

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Directed bench for sd_drive_arbiter: reset, read, round-robin, write, timeout,
// short/long transfers, ignored strobes and asynchronous reset mid-transfer.
module tb_sd_drive_arbiter;

  logic        clk_sys = 1'b0;
  logic        res_n;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_lba0, req_lba1;
  logic [7:0]  drv_din0, drv_din1;
  logic [1:0]  grant, done, err;
  logic        busy;
  logic [1:0]  drv_dout_strobe, drv_din_strobe;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic [7:0]  sd_din;
  logic        sd_ack, sd_dout_strobe, sd_din_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  sd_drive_arbiter #(.TIMEOUT_W(4), .SECTOR_LEN(512)) dut (
    .clk_sys         (clk_sys),
    .res_n           (res_n),
    .req_rd          (req_rd),
    .req_wr          (req_wr),
    .req_lba0        (req_lba0),
    .req_lba1        (req_lba1),
    .drv_din0        (drv_din0),
    .drv_din1        (drv_din1),
    .grant           (grant),
    .done            (done),
    .err             (err),
    .busy            (busy),
    .drv_dout_strobe (drv_dout_strobe),
    .drv_din_strobe  (drv_din_strobe),
    .sd_lba          (sd_lba),
    .sd_rd           (sd_rd),
    .sd_wr           (sd_wr),
    .sd_din          (sd_din),
    .sd_ack          (sd_ack),
    .sd_dout_strobe  (sd_dout_strobe),
    .sd_din_strobe   (sd_din_strobe)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic do_reset();
    res_n = 1'b0;
    req_rd = 2'b00; req_wr = 2'b00;
    req_lba0 = 32'd0; req_lba1 = 32'd0;
    drv_din0 = 8'd0; drv_din1 = 8'd0;
    sd_ack = 1'b0; sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0;
    repeat (2) @(negedge clk_sys);
    res_n = 1'b1;
    @(negedge clk_sys);
  endtask

  // Starts at a negedge with the arbiter in REQ; ends at the negedge after returning to IDLE.
  task automatic serve(input int ack_dly, input int nstb, input bit use_dout,
                       output int fwd, output logic [1:0] gnt, output logic [1:0] dn,
                       output logic [1:0] er, output logic [7:0] din_seen);
    gnt = grant;
    din_seen = 8'h00;
    repeat (ack_dly) @(negedge clk_sys);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    fwd = 0;
    for (int i = 0; i < nstb; i++) begin
      if (use_dout) sd_dout_strobe = 1'b1; else sd_din_strobe = 1'b1;
      #1;
      if ((use_dout ? drv_dout_strobe : drv_din_strobe) == gnt) fwd++;
      din_seen = sd_din;
      @(negedge clk_sys);
      sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0;
      @(negedge clk_sys);
    end
    sd_ack = 1'b0;
    dn = 2'b00; er = 2'b00;
    for (int i = 0; i < 8 && (dn | er) == 2'b00; i++) begin
      @(negedge clk_sys);
      dn = done; er = err;
    end
    if (gnt[0]) begin req_rd[0] = 1'b0; req_wr[0] = 1'b0; end
    if (gnt[1]) begin req_rd[1] = 1'b0; req_wr[1] = 1'b0; end
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant got %b want 00", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({sd_rd, sd_wr, done, err} !== 8'h00) begin
      n_bad++; $display("FAIL reset_ctl got %h want 00", {sd_rd, sd_wr, done, err});
    end
    n_cmp++; if (sd_lba !== 32'd0) begin n_bad++; $display("FAIL reset_lba got %h want 0", sd_lba); end
  endtask

  task automatic test_read();
    int fwd; logic [1:0] g, dn, er; logic [7:0] d;
    req_lba0 = 32'h123; req_rd = 2'b01;
    @(negedge clk_sys);
    n_cmp++; if (sd_rd !== 2'b01) begin n_bad++; $display("FAIL rd_sd_rd got %b want 01", sd_rd); end
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rd_grant got %b want 01", grant); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy got %b want 1", busy); end
    req_lba0 = 32'hdead;
    @(negedge clk_sys);
    n_cmp++; if (sd_lba !== 32'h123) begin n_bad++; $display("FAIL rd_lba got %h want 123", sd_lba); end
    serve(4, 512, 1'b1, fwd, g, dn, er, d);
    n_cmp++; if (fwd !== 512) begin n_bad++; $display("FAIL rd_fwd got %0d want 512", fwd); end
    n_cmp++; if (dn !== 2'b01 || er !== 2'b00) begin
      n_bad++; $display("FAIL rd_done got done=%b err=%b want 01/00", dn, er);
    end
    n_cmp++; if (grant !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rd_idle got grant=%b busy=%b want 00/0", grant, busy);
    end
  endtask

  task automatic test_round_robin();
    int fwd; logic [1:0] g, dn, er; logic [7:0] d;
    logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req_lba0 = 32'h111; req_lba1 = 32'h456;
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || k == 2) begin
        req_rd = 2'b11;
        @(negedge clk_sys);
      end else begin
        @(negedge clk_sys);
      end
      n_cmp++; if (grant !== exp_order[k]) begin
        n_bad++; $display("FAIL rr_grant%0d got %b want %b", k, grant, exp_order[k]);
      end
      n_cmp++; if (sd_lba !== (exp_order[k][1] ? 32'h456 : 32'h111)) begin
        n_bad++; $display("FAIL rr_lba%0d got %h", k, sd_lba);
      end
      serve(1, 512, 1'b1, fwd, g, dn, er, d);
      n_cmp++; if (dn !== exp_order[k]) begin
        n_bad++; $display("FAIL rr_done%0d got %b want %b", k, dn, exp_order[k]);
      end
    end
  endtask

  task automatic test_write();
    int fwd; logic [1:0] g, dn, er; logic [7:0] d;
    req_lba1 = 32'd7; drv_din1 = 8'ha5; drv_din0 = 8'h3c; req_wr = 2'b10;
    @(negedge clk_sys);
    n_cmp++; if (sd_wr !== 2'b10 || sd_rd !== 2'b00) begin
      n_bad++; $display("FAIL wr_ctl got wr=%b rd=%b want 10/00", sd_wr, sd_rd);
    end
    n_cmp++; if (sd_lba !== 32'd7) begin n_bad++; $display("FAIL wr_lba got %h want 7", sd_lba); end
    serve(2, 512, 1'b0, fwd, g, dn, er, d);
    n_cmp++; if (d !== 8'ha5) begin n_bad++; $display("FAIL wr_din got %h want a5", d); end
    n_cmp++; if (fwd !== 512) begin n_bad++; $display("FAIL wr_fwd got %0d want 512", fwd); end
    n_cmp++; if (dn !== 2'b10) begin n_bad++; $display("FAIL wr_done got %b want 10", dn); end
    n_cmp++; if (sd_din !== 8'h00) begin n_bad++; $display("FAIL wr_din_idle got %h want 00", sd_din); end
  endtask

  task automatic test_timeout();
    int cyc; logic [1:0] er;
    req_rd = 2'b01;
    @(negedge clk_sys);
    cyc = 0; er = err;
    while (er == 2'b00 && cyc < 40) begin
      @(negedge clk_sys);
      cyc++;
      er = err;
    end
    n_cmp++; if (er !== 2'b01) begin n_bad++; $display("FAIL tmo_err got %b want 01", er); end
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL tmo_cycles got %0d want 15", cyc); end
    req_rd = 2'b00;
    @(negedge clk_sys);
    n_cmp++; if (sd_rd !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL tmo_idle got rd=%b grant=%b busy=%b want 00/00/0", sd_rd, grant, busy);
    end
  endtask

  task automatic test_bad_length();
    int fwd; logic [1:0] g, dn, er; logic [7:0] d;
    req_rd = 2'b01;
    @(negedge clk_sys);
    serve(1, 100, 1'b1, fwd, g, dn, er, d);
    n_cmp++; if (er !== 2'b01 || dn !== 2'b00) begin
      n_bad++; $display("FAIL short_err got err=%b done=%b want 01/00", er, dn);
    end
    sd_dout_strobe = 1'b1; sd_din_strobe = 1'b1;
    #1;
    n_cmp++; if ({drv_dout_strobe, drv_din_strobe} !== 4'h0) begin
      n_bad++; $display("FAIL idle_strobe got %h want 0", {drv_dout_strobe, drv_din_strobe});
    end
    @(negedge clk_sys);
    sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0;
    req_rd = 2'b01;
    @(negedge clk_sys);
    sd_dout_strobe = 1'b1;
    #1;
    n_cmp++; if (drv_dout_strobe !== 2'b00) begin
      n_bad++; $display("FAIL req_strobe got %b want 00", drv_dout_strobe);
    end
    @(negedge clk_sys);
    sd_dout_strobe = 1'b0;
    serve(0, 512, 1'b1, fwd, g, dn, er, d);
    n_cmp++; if (dn !== 2'b01) begin n_bad++; $display("FAIL req_strobe_done got %b want 01", dn); end
    req_rd = 2'b01;
    @(negedge clk_sys);
    serve(0, 513, 1'b1, fwd, g, dn, er, d);
    n_cmp++; if (er !== 2'b01 || dn !== 2'b00) begin
      n_bad++; $display("FAIL long_err got err=%b done=%b want 01/00", er, dn);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int fwd; logic [1:0] g, dn, er; logic [7:0] d;
    req_lba1 = 32'h99; req_rd = 2'b10;
    @(negedge clk_sys);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    sd_dout_strobe = 1'b1;
    #1;
    n_cmp++; if (drv_dout_strobe !== 2'b10) begin
      n_bad++; $display("FAIL xfer_fwd_b got %b want 10", drv_dout_strobe);
    end
    res_n = 1'b0;
    #1;
    n_cmp++; if ({grant, busy, sd_rd, sd_wr, done, err, drv_dout_strobe} !== 13'd0) begin
      n_bad++; $display("FAIL async_reset got %h want 0",
                        {grant, busy, sd_rd, sd_wr, done, err, drv_dout_strobe});
    end
    n_cmp++; if (sd_lba !== 32'd0) begin n_bad++; $display("FAIL async_reset_lba got %h want 0", sd_lba); end
    @(negedge clk_sys);
    sd_ack = 1'b0; sd_dout_strobe = 1'b0; req_rd = 2'b00;
    @(negedge clk_sys);
    res_n = 1'b1;
    @(negedge clk_sys);
    req_rd = 2'b11;
    @(negedge clk_sys);
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL post_reset_grant got %b want 01", grant); end
    serve(1, 512, 1'b1, fwd, g, dn, er, d);
    n_cmp++; if (dn !== 2'b01) begin n_bad++; $display("FAIL post_reset_done_a got %b want 01", dn); end
    @(negedge clk_sys);
    serve(1, 512, 1'b1, fwd, g, dn, er, d);
    n_cmp++; if (dn !== 2'b10) begin n_bad++; $display("FAIL post_reset_done_b got %b want 10", dn); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_bad_length();
    test_reset_mid_xfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
